// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD bitmap overlay path.
package osd_pkg;

    localparam int unsigned RGB_W        = 24;
    localparam int unsigned PIX_PER_BYTE = 8;

    // One pixel-clock beat of the video stream.
    typedef struct packed {
        logic             vs;
        logic             hs;
        logic             de;
        logic [RGB_W-1:0] rgb;
    } video_bus_t;

    // Number of ROM bytes that make up one line of the OSD window.
    function automatic int unsigned osd_bytes_per_row(input int unsigned osd_w);
        return osd_w / PIX_PER_BYTE;
    endfunction

endpackage

// File: rtl/osd_video_delay.sv
// N-stage shift register that carries the video bus alongside the ROM pipeline.
module osd_video_delay
    import osd_pkg::*;
#(
    parameter int unsigned N = 3
)(
    input  logic       i_clk,
    input  logic       i_rst,
    input  video_bus_t i_bus,
    output video_bus_t o_bus
);

    video_bus_t r_pipe [N];

    // Shift the bus one stage per pixel clock; reset empties every stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_bus;
            for (int unsigned i = 1; i < N; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_bus = r_pipe[N-1];

endmodule

// File: rtl/osd_bitmap_reader.sv
// Reads a 1-bpp OSD bitmap from ROM and overlays it as a solid colour on the video stream.
module osd_bitmap_reader
    import osd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OSD_W      = 256,
    parameter int unsigned OSD_H      = 64,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned ROM_LAT    = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           pos_x,
    input  logic [11:0]           pos_y,
    input  logic                  osd_en,
    input  logic [RGB_W-1:0]      osd_color,
    input  logic                  vs_in,
    input  logic                  hs_in,
    input  logic                  de_in,
    input  logic [RGB_W-1:0]      rgb_in,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  vs_out,
    output logic                  hs_out,
    output logic                  de_out,
    output logic [RGB_W-1:0]      rgb_out
);

    localparam int unsigned LAT           = ROM_LAT + 2;
    localparam int unsigned BYTES_PER_ROW = osd_bytes_per_row(OSD_W);

    // Edge detectors and pixel position
    logic              r_vs_act_d;
    logic              r_de_d;
    logic [11:0]       r_x_cnt;
    logic [11:0]       r_y_cnt;
    logic              w_vs_act;
    logic              w_vs_edge;
    logic              w_de_fall;

    // Per-frame shadow of the control inputs
    logic              r_en_l;
    logic [11:0]       r_pos_x_l;
    logic [11:0]       r_pos_y_l;
    logic [RGB_W-1:0]  r_color_l;

    // Stage 0 window test and address
    logic signed [12:0]    w_rx;
    logic signed [12:0]    w_ry;
    logic                  w_rx_in;
    logic                  w_ry_in;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_hit_s0;
    logic [2:0]            r_sub_s0;

    // ROM-latency alignment and final select
    logic [ROM_LAT-1:0]    r_hit_pipe;
    logic [2:0]            r_sub_pipe [ROM_LAT];
    logic                  w_bit;
    logic                  r_ovl;

    video_bus_t            w_bus_in;
    video_bus_t            w_bus_d;

    assign w_vs_act  = (vs_in == VS_POL);
    assign w_vs_edge = w_vs_act & ~r_vs_act_d;
    assign w_de_fall = r_de_d & ~de_in;

    // Track the active-pixel position of the incoming stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_act_d <= 1'b0;
            r_de_d     <= 1'b0;
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
        end else begin
            r_vs_act_d <= w_vs_act;
            r_de_d     <= de_in;
            r_x_cnt    <= de_in ? r_x_cnt + 12'd1 : '0;
            if (w_vs_edge) begin
                r_y_cnt <= '0;
            end else if (w_de_fall) begin
                r_y_cnt <= r_y_cnt + 12'd1;
            end
        end
    end

    // Capture enable, position and colour once per frame so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_l    <= 1'b0;
            r_pos_x_l <= '0;
            r_pos_y_l <= '0;
            r_color_l <= '0;
        end else if (w_vs_edge) begin
            r_en_l    <= osd_en;
            r_pos_x_l <= pos_x;
            r_pos_y_l <= pos_y;
            r_color_l <= osd_color;
        end
    end

    // Window-relative coordinates; negative means left of / above the window.
    assign w_rx    = $signed({1'b0, r_x_cnt}) - $signed({1'b0, r_pos_x_l});
    assign w_ry    = $signed({1'b0, r_y_cnt}) - $signed({1'b0, r_pos_y_l});
    assign w_rx_in = ~w_rx[12] && (32'(w_rx[11:0]) < OSD_W);
    assign w_ry_in = ~w_ry[12] && (32'(w_ry[11:0]) < OSD_H);
    assign w_hit   = de_in & r_en_l & w_rx_in & w_ry_in;
    assign w_addr  = ADDR_WIDTH'(32'(w_ry[11:0]) * BYTES_PER_ROW + 32'(w_rx[11:3]));

    assign w_bit   = rom_data[3'd7 - r_sub_pipe[ROM_LAT-1]];

    // Address issue, hit/sub-pixel alignment to the ROM latency, and overlay decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_hit_s0   <= 1'b0;
            r_sub_s0   <= '0;
            r_hit_pipe <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                r_sub_pipe[i] <= '0;
            end
            r_ovl      <= 1'b0;
        end else begin
            if (w_hit) begin
                r_rom_addr <= w_addr;
            end
            r_hit_s0      <= w_hit;
            r_sub_s0      <= w_rx[2:0];
            r_hit_pipe[0] <= r_hit_s0;
            r_sub_pipe[0] <= r_sub_s0;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                r_hit_pipe[i] <= r_hit_pipe[i-1];
                r_sub_pipe[i] <= r_sub_pipe[i-1];
            end
            r_ovl         <= r_hit_pipe[ROM_LAT-1] & w_bit;
        end
    end

    assign w_bus_in = {vs_in, hs_in, de_in, rgb_in};

    osd_video_delay #(
        .N (LAT)
    ) u_video_delay (
        .i_clk (clk),
        .i_rst (rst),
        .i_bus (w_bus_in),
        .o_bus (w_bus_d)
    );

    // Overlay flag and delayed video are both registered and line up on the same beat.
    assign rom_addr = r_rom_addr;
    assign vs_out   = w_bus_d.vs;
    assign hs_out   = w_bus_d.hs;
    assign de_out   = w_bus_d.de;
    assign rgb_out  = r_ovl ? r_color_l : w_bus_d.rgb;

endmodule

// File: tb/tb_osd_bitmap_reader.sv
// Directed bench for osd_bitmap_reader: scaled-down frames, behavioural ROM, pixel-coordinate reference.
module tb_osd_bitmap_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pos_x, pos_y;
    logic        osd_en;
    logic [23:0] osd_color;
    logic        vs_in, hs_in, de_in;
    logic [23:0] rgb_in;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        vs_out, hs_out, de_out;
    logic [23:0] rgb_out;

    logic [7:0]  rom [2048];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [26:0] hist [4];
    int unsigned cyc;
    logic        m_en;
    logic [11:0] m_px, m_py;
    logic [23:0] m_col;
    int          prev_x, prev_y;

    // Per-frame results
    int          fr_mism, fr_ovl_exp, fr_ovl_obs, fr_rst_bad;
    int unsigned fm_cyc;
    logic [26:0] fm_got, fm_exp;
    logic [10:0] fr_max_addr;
    logic [10:0] line0_addr [64];

    always #5 clk = ~clk;

    // Registered-read ROM, one cycle latency, no output register.
    always @(posedge clk) rom_data <= rom[rom_addr];

    osd_bitmap_reader #(
        .ADDR_WIDTH (11),
        .DATA_WIDTH (8),
        .OSD_W      (256),
        .OSD_H      (64),
        .VS_POL     (1'b1),
        .ROM_LAT    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .osd_en    (osd_en),
        .osd_color (osd_color),
        .vs_in     (vs_in),
        .hs_in     (hs_in),
        .de_in     (de_in),
        .rgb_in    (rgb_in),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .vs_out    (vs_out),
        .hs_out    (hs_out),
        .de_out    (de_out),
        .rgb_out   (rgb_out)
    );

    task automatic rom_fill(input logic [7:0] v);
        for (int i = 0; i < 2048; i++) rom[i] = v;
    endtask

    // One pixel clock: drive inputs, predict the output 3 beats later, sample at negedge.
    task automatic step(input logic v, input logic h, input logic d, input logic [23:0] rgb,
                        input bit in_rst, input int x, input int y);
        logic        ovl;
        int          rx, ry;
        logic [26:0] got, ex;
        vs_in = v; hs_in = h; de_in = d; rgb_in = rgb;
        ovl = 1'b0;
        if (!in_rst && d && m_en) begin
            rx = x - int'(m_px);
            ry = y - int'(m_py);
            if (rx >= 0 && rx < 256 && ry >= 0 && ry < 64)
                ovl = rom[ry*32 + rx/8][7 - rx%8];
        end
        if (ovl) fr_ovl_exp++;
        hist[cyc%4] = in_rst ? 27'd0 : {v, h, d, (ovl ? m_col : rgb)};
        @(negedge clk);
        got = {vs_out, hs_out, de_out, rgb_out};
        ex  = hist[(cyc+1)%4];
        if (got !== ex) begin
            if (fr_mism == 0) begin fm_cyc = cyc; fm_got = got; fm_exp = ex; end
            fr_mism++;
        end
        if (de_out === 1'b1 && rgb_out === m_col) fr_ovl_obs++;
        if (in_rst && (got !== 27'd0 || rom_addr !== 11'd0)) fr_rst_bad++;
        if (prev_y == 0 && prev_x >= 0 && prev_x < 64) line0_addr[prev_x] = rom_addr;
        prev_x = d ? x : -1;
        prev_y = d ? y : -1;
        if (rom_addr > fr_max_addr) fr_max_addr = rom_addr;
        @(posedge clk); #1;
        cyc++;
    endtask

    // One frame: vs pulse, then v_act lines of h_act pixels plus 8 blanking beats with an hs pulse.
    task automatic run_frame(input int h_act, input int v_act, input bit rnd,
                             input int off_line, input int rst_line);
        fr_mism = 0; fr_ovl_exp = 0; fr_ovl_obs = 0; fr_rst_bad = 0; fr_max_addr = '0;
        m_en = osd_en; m_px = pos_x; m_py = pos_y; m_col = osd_color;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, -1, -1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, -1, -1);
        for (int y = 0; y < v_act; y++) begin
            if (y == off_line) begin
                osd_en    = 1'b0;
                pos_x     = pos_x + 12'd3;
                osd_color = ~osd_color;
            end
            if (y == rst_line) begin
                rst = 1'b1;
                for (int k = 0; k < 4; k++) hist[k] = '0;
                for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 24'h0, 1'b1, -1, -1);
                rst  = 1'b0;
                m_en = 1'b0;
            end
            for (int x = 0; x < h_act; x++)
                step(1'b0, 1'b0, 1'b1, (rnd ? 24'($urandom) : {8'h00, 8'(x), 8'(y)}), 1'b0, x, y);
            for (int b = 0; b < 8; b++)
                step(1'b0, (b == 2 || b == 3), 1'b0, 24'h0, 1'b0, -1, -1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vs_in = 1'b1; hs_in = 1'b1; de_in = 1'b1; rgb_in = 24'hFFFFFF;
        osd_en = 1'b1; pos_x = '0; pos_y = '0; osd_color = 24'hFFFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (vs_out !== 1'b0) begin n_fail++; $display("FAIL reset_vs: got %b exp 0", vs_out); end
        n_tests++; if (hs_out !== 1'b0) begin n_fail++; $display("FAIL reset_hs: got %b exp 0", hs_out); end
        n_tests++; if (de_out !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b exp 0", de_out); end
        n_tests++; if (rgb_out !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h exp 000000", rgb_out); end
        n_tests++; if (rom_addr !== 11'h0) begin n_fail++; $display("FAIL reset_addr: got %0d exp 0", rom_addr); end
        vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; rgb_in = '0; osd_en = 1'b0; osd_color = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < 4; k++) hist[k] = '0;
        prev_x = -1; prev_y = -1;
    endtask

    task automatic test_overlay();
        rom_fill(8'h80);
        osd_en = 1'b1; pos_x = 12'd100; pos_y = 12'd5; osd_color = 24'hF00FA5;
        run_frame(360, 72, 1'b0, -1, -1);
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL overlay_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_exp !== 2048) begin n_fail++; $display("FAIL overlay_model_count: got %0d exp 2048", fr_ovl_exp); end
        n_tests++; if (fr_ovl_obs !== 2048) begin n_fail++; $display("FAIL overlay_count: got %0d exp 2048", fr_ovl_obs); end
        n_tests++; if (fr_max_addr !== 11'd2047) begin n_fail++; $display("FAIL overlay_max_addr: got %0d exp 2047", fr_max_addr); end
    endtask

    task automatic test_unaligned();
        rom_fill(8'h00);
        rom[0] = 8'hFF; rom[1] = 8'h00;
        osd_en = 1'b1; pos_x = 12'd5; pos_y = 12'd0; osd_color = 24'h3C55C3;
        run_frame(40, 2, 1'b0, -1, -1);
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL unaligned_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_exp !== 8) begin n_fail++; $display("FAIL unaligned_model_count: got %0d exp 8", fr_ovl_exp); end
        n_tests++; if (fr_ovl_obs !== 8) begin n_fail++; $display("FAIL unaligned_count: got %0d exp 8", fr_ovl_obs); end
        n_tests++; if (line0_addr[12] !== 11'd0) begin n_fail++; $display("FAIL unaligned_addr_x12: got %0d exp 0", line0_addr[12]); end
        n_tests++; if (line0_addr[13] !== 11'd1) begin n_fail++; $display("FAIL unaligned_addr_x13: got %0d exp 1", line0_addr[13]); end
        n_tests++; if (line0_addr[21] !== 11'd2) begin n_fail++; $display("FAIL unaligned_addr_x21: got %0d exp 2", line0_addr[21]); end
    endtask

    task automatic test_clip();
        rom_fill(8'hFF);
        osd_en = 1'b1; pos_x = 12'd24; pos_y = 12'd4; osd_color = 24'h5AA55A;
        run_frame(64, 24, 1'b0, -1, -1);
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL clip_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_obs !== 800) begin n_fail++; $display("FAIL clip_count: got %0d exp 800", fr_ovl_obs); end
        n_tests++; if (fr_max_addr !== 11'd612) begin n_fail++; $display("FAIL clip_max_addr: got %0d exp 612", fr_max_addr); end
        pos_x = 12'd2000; pos_y = 12'd2000;
        run_frame(64, 24, 1'b0, -1, -1);
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL offscreen_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_obs !== 0) begin n_fail++; $display("FAIL offscreen_count: got %0d exp 0", fr_ovl_obs); end
    endtask

    task automatic test_en_toggle();
        rom_fill(8'h80);
        osd_en = 1'b1; pos_x = 12'd8; pos_y = 12'd2; osd_color = 24'h123456;
        run_frame(48, 16, 1'b0, 6, -1);
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL toggle_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_exp !== 70) begin n_fail++; $display("FAIL toggle_model_count: got %0d exp 70", fr_ovl_exp); end
        n_tests++; if (fr_ovl_obs !== 70) begin n_fail++; $display("FAIL toggle_count: got %0d exp 70", fr_ovl_obs); end
        osd_color = 24'h123456;
        run_frame(48, 16, 1'b0, -1, -1);
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL toggle_next_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_obs !== 0) begin n_fail++; $display("FAIL toggle_next_count: got %0d exp 0", fr_ovl_obs); end
    endtask

    task automatic test_reset_midframe();
        rom_fill(8'hFF);
        osd_en = 1'b1; pos_x = 12'd0; pos_y = 12'd0; osd_color = 24'hABCDEF;
        run_frame(32, 16, 1'b0, -1, 8);
        n_tests++; if (fr_rst_bad !== 0) begin n_fail++; $display("FAIL midrst_outputs: %0d nonzero beats in reset, exp 0", fr_rst_bad); end
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL midrst_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_obs !== 256) begin n_fail++; $display("FAIL midrst_count: got %0d exp 256", fr_ovl_obs); end
        run_frame(32, 16, 1'b0, -1, -1);
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL midrst_next_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_obs !== 512) begin n_fail++; $display("FAIL midrst_next_count: got %0d exp 512", fr_ovl_obs); end
    endtask

    task automatic test_passthrough();
        rom_fill(8'hFF);
        osd_en = 1'b0; pos_x = 12'd0; pos_y = 12'd0; osd_color = 24'h00FF00;
        run_frame(64, 24, 1'b1, -1, -1);
        n_tests++; if (fr_mism !== 0) begin n_fail++;
            $display("FAIL passthru_stream: %0d bad beats, first cyc %0d got %h exp %h", fr_mism, fm_cyc, fm_got, fm_exp); end
        n_tests++; if (fr_ovl_exp !== 0) begin n_fail++; $display("FAIL passthru_model_count: got %0d exp 0", fr_ovl_exp); end
    endtask

    initial begin
        rom_fill(8'h00);
        test_reset();
        test_overlay();
        test_unaligned();
        test_clip();
        test_en_toggle();
        test_reset_midframe();
        test_passthrough();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
